// File: rtl/bcd_counter_99.sv
// Two-digit BCD up/down counter (00-99) with a step prescaler and a free-running
// display-refresh toggle that selects the digit on the multiplexed display.
module bcd_counter_99 #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up_dn,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic       refreshcounter,
    output logic       wrap
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc;
    logic [RW-1:0] rdiv;
    logic [3:0]    nxt_ones, nxt_tens, ld_ones, ld_tens;
    logic          step, at_end;

    assign step    = en && (presc == P_LAST);
    assign ld_ones = (load_ones > 4'd9) ? 4'd9 : load_ones;
    assign ld_tens = (load_tens > 4'd9) ? 4'd9 : load_tens;

    // Any digit >= 9 is treated as the carry/borrow point so no path exceeds 9.
    always_comb begin
        nxt_ones = digit1;
        nxt_tens = digit2;
        at_end   = 1'b0;
        if (up_dn) begin
            if (digit1 >= 4'd9) begin
                nxt_ones = 4'd0;
                if (digit2 >= 4'd9) begin
                    nxt_tens = 4'd0;
                    at_end   = 1'b1;
                end else begin
                    nxt_tens = digit2 + 4'd1;
                end
            end else begin
                nxt_ones = digit1 + 4'd1;
            end
        end else begin
            if (digit1 == 4'd0) begin
                nxt_ones = 4'd9;
                if (digit2 == 4'd0) begin
                    nxt_tens = 4'd9;
                    at_end   = 1'b1;
                end else begin
                    nxt_tens = digit2 - 4'd1;
                end
            end else begin
                nxt_ones = digit1 - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc  <= '0;
            digit1 <= 4'd0;
            digit2 <= 4'd0;
            wrap   <= 1'b0;
        end else if (clear) begin
            presc  <= '0;
            digit1 <= 4'd0;
            digit2 <= 4'd0;
            wrap   <= 1'b0;
        end else if (load) begin
            presc  <= '0;
            digit1 <= ld_ones;
            digit2 <= ld_tens;
            wrap   <= 1'b0;
        end else begin
            wrap <= step && at_end;
            if (en)
                presc <= (presc == P_LAST) ? '0 : presc + PW'(1);
            if (step) begin
                digit1 <= nxt_ones;
                digit2 <= nxt_tens;
            end
        end
    end

    // Refresh divider runs regardless of en/clear/load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdiv           <= '0;
            refreshcounter <= 1'b0;
        end else if (rdiv == R_LAST) begin
            rdiv           <= '0;
            refreshcounter <= ~refreshcounter;
        end else begin
            rdiv <= rdiv + RW'(1);
        end
    end
endmodule

// File: tb/tb_bcd_counter_99.sv
// Directed bench for bcd_counter_99 with TICK_DIV=4, REFRESH_DIV=3.
module tb_bcd_counter_99;
    logic       clk = 1'b0;
    logic       rst_n, en, up_dn, clear, load;
    logic [3:0] load_tens, load_ones;
    logic [3:0] digit1, digit2;
    logic       refreshcounter, wrap;
    int         checks = 0;
    int         errors = 0;
    int         ecount = 0;

    bcd_counter_99 #(.TICK_DIV(4), .REFRESH_DIV(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_tens(load_tens), .load_ones(load_ones),
        .digit1(digit1), .digit2(digit2),
        .refreshcounter(refreshcounter), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Edges since reset release; refreshcounter is expected at (ecount/3)%2.
    always @(posedge clk) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rst_n) chk("refresh", refreshcounter, (ecount / 3) % 2);
        end
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load_tens = t;
        load_ones = o;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
        load_tens = 4'd0; load_ones = 4'd0;

        // Reset and first-step latency
        tick(2);
        chk("rst_digits", {digit2, digit1}, 8'h00);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_refresh", refreshcounter, 1'b0);
        rst_n = 1'b1;
        tick(3);
        chk("pre_step", {digit2, digit1}, 8'h00);
        tick();
        chk("step1", {digit2, digit1}, 8'h01);
        tick(4);
        chk("step2", {digit2, digit1}, 8'h02);

        // Up carry and wrap
        do_load(4'd9, 4'd8);
        chk("load98", {digit2, digit1}, 8'h98);
        tick(4);
        chk("up99", {digit2, digit1}, 8'h99);
        chk("up99_wrap", wrap, 1'b0);
        tick(4);
        chk("up00", {digit2, digit1}, 8'h00);
        chk("up_wrap", wrap, 1'b1);
        tick();
        chk("up_wrap_drop", wrap, 1'b0);
        tick(3);
        chk("up01", {digit2, digit1}, 8'h01);

        // Down borrow and wrap
        up_dn = 1'b0;
        do_load(4'd1, 4'd0);
        tick(4);
        chk("dn09", {digit2, digit1}, 8'h09);
        tick(4);
        chk("dn08", {digit2, digit1}, 8'h08);
        do_load(4'd0, 4'd0);
        tick(3);
        chk("dn00_hold", {digit2, digit1}, 8'h00);
        tick();
        chk("dn99", {digit2, digit1}, 8'h99);
        chk("dn_wrap", wrap, 1'b1);
        tick();
        chk("dn_wrap_drop", wrap, 1'b0);

        // Freeze: prescaler holds at 2 while en is low
        up_dn = 1'b1;
        do_load(4'd5, 4'd0);
        tick(2);
        en = 1'b0;
        tick(5);
        chk("freeze_mid", {digit2, digit1}, 8'h50);
        tick(5);
        chk("freeze_end", {digit2, digit1}, 8'h50);
        en = 1'b1;
        tick();
        chk("resume1", {digit2, digit1}, 8'h50);
        tick();
        chk("resume2", {digit2, digit1}, 8'h51);

        // Priority: clear+load on a step edge
        do_load(4'd4, 4'd2);
        tick(3);
        clear = 1'b1; load = 1'b1; load_tens = 4'd7; load_ones = 4'd7;
        tick();
        clear = 1'b0; load = 1'b0;
        chk("clr_win", {digit2, digit1}, 8'h00);
        chk("clr_wrap", wrap, 1'b0);
        tick(3);
        chk("clr_presc", {digit2, digit1}, 8'h00);
        tick();
        chk("clr_step", {digit2, digit1}, 8'h01);
        do_load(4'd12, 4'd15);
        chk("load_sat", {digit2, digit1}, 8'h99);
        tick(3);
        do_load(4'd9, 4'd9);
        chk("load_on_wrap", {digit2, digit1}, 8'h99);
        chk("load_no_wrap", wrap, 1'b0);

        // Refresh unaffected by en/clear/load pulses (checked every tick)
        en = 1'b0; tick();
        en = 1'b1; clear = 1'b1; tick();
        clear = 1'b0; tick();
        do_load(4'd3, 4'd3);
        en = 1'b0; tick(2);
        en = 1'b1; clear = 1'b1; tick();
        clear = 1'b0; tick();
        do_load(4'd1, 4'd1);
        tick(3);
        chk("refresh_end_digits", {digit2, digit1}, 8'h11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
